// File: rtl/trace_plotter.sv
// Scope trace writer: per accepted sample, clears one framebuffer column, then draws the segment from the previous sample.
// Latency: V_RES clear writes plus (hi-lo+1) trace writes per sample, one write per cycle, all outputs registered.
// Backpressure: o_sample_ready is high only in IDLE while i_freeze is low; optional grid via `TRACE_PLOTTER_GRATICULE_EN.
module trace_plotter #(
  parameter int         SAMPLE_W = 8,
  parameter int         H_RES    = 640,
  parameter int         V_RES    = 480,
  parameter int         Y_OFFSET = 112,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter logic [2:0] TR_COLOR = 3'b010
`ifdef TRACE_PLOTTER_GRATICULE_EN
  ,
  parameter logic [2:0] GRID_COLOR = 3'b001,
  parameter int         GRID_STEP  = 32
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic                o_sample_ready,
  input  logic                i_freeze,
  output logic                o_wr_en,
  output logic [18:0]         o_wr_addr,
  output logic [2:0]          o_wr_data,
  output logic [9:0]          o_cur_col,
  output logic                o_frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW} state_t;

  localparam logic [9:0] FULL_Y = 10'((1 << SAMPLE_W) - 1);
  localparam logic [9:0] Y_OFF  = 10'(Y_OFFSET);
  localparam logic [9:0] V_MAX  = 10'(V_RES - 1);
  localparam logic [8:0] V_LAST = 9'(V_RES - 1);
  localparam logic [9:0] X_LAST = 10'(H_RES - 1);

  state_t      state_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [8:0]  hi_q;
  logic [8:0]  cur_y_q;
  logic [8:0]  prev_y_q;
  logic        prev_valid_q;
  logic        alive_q;
  logic        wr_en_q;
  logic [18:0] wr_addr_q;
  logic [2:0]  wr_data_q;
  logic        frame_done_q;

  logic [9:0]  y_raw_d;
  logic [8:0]  y_map_d;
  logic [8:0]  y_nxt_d;
  logic        single_d;
  logic [8:0]  lo_d;
  logic [8:0]  hi_d;
  logic        accept_d;
  logic [2:0]  clr_first_d;
  logic [2:0]  clr_next_d;

`ifdef TRACE_PLOTTER_GRATICULE_EN
  function automatic logic [2:0] clear_color(input logic [9:0] x, input logic [8:0] y);
    if (((y % 9'(GRID_STEP)) == 9'd0) || ((x % 10'(GRID_STEP)) == 10'd0) ||
        (y == 9'(V_RES / 2)))
      return GRID_COLOR;
    else
      return BG_COLOR;
  endfunction
`endif

  // Sample to row mapping, segment bounds and clear colour for the next write.
  always_comb begin
    y_raw_d  = Y_OFF + (FULL_Y - 10'(i_sample));
    y_map_d  = (y_raw_d > V_MAX) ? V_LAST : y_raw_d[8:0];
    y_nxt_d  = y_q + 9'd1;
    // First sample after reset and column 0 never link back to an older column.
    single_d = !prev_valid_q || (x_q == 10'd0);
    if (single_d) begin
      lo_d = cur_y_q;
      hi_d = cur_y_q;
    end else if (prev_y_q < cur_y_q) begin
      lo_d = prev_y_q;
      hi_d = cur_y_q;
    end else begin
      lo_d = cur_y_q;
      hi_d = prev_y_q;
    end
`ifdef TRACE_PLOTTER_GRATICULE_EN
    clr_first_d = clear_color(x_q, 9'd0);
    clr_next_d  = clear_color(x_q, y_nxt_d);
`else
    clr_first_d = BG_COLOR;
    clr_next_d  = BG_COLOR;
`endif
  end

  // alive_q keeps ready low while reset is held and for the first cycle after.
  assign o_sample_ready = alive_q && (state_q == S_IDLE) && !i_freeze;
  assign accept_d       = o_sample_ready && i_sample_valid;

  // Column FSM; each write's address/data is set on the edge entering that cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      hi_q         <= '0;
      cur_y_q      <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      alive_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      alive_q      <= 1'b1;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            cur_y_q   <= y_map_d;
            y_q       <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= {x_q, 9'd0};
            wr_data_q <= clr_first_d;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (y_q == V_LAST) begin
            y_q       <= lo_d;
            hi_q      <= hi_d;
            wr_addr_q <= {x_q, lo_d};
            wr_data_q <= TR_COLOR;
            state_q   <= S_DRAW;
          end else begin
            y_q       <= y_nxt_d;
            wr_addr_q <= {x_q, y_nxt_d};
            wr_data_q <= clr_next_d;
          end
        end
        S_DRAW: begin
          if (y_q == hi_q) begin
            wr_en_q      <= 1'b0;
            prev_y_q     <= cur_y_q;
            prev_valid_q <= 1'b1;
            x_q          <= (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
            frame_done_q <= (x_q == X_LAST);
            state_q      <= S_IDLE;
          end else begin
            y_q       <= y_nxt_d;
            wr_addr_q <= {x_q, y_nxt_d};
            wr_data_q <= TR_COLOR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_cur_col    = x_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_trace_plotter.sv
// Directed bench for trace_plotter: instance A uses default parameters,
// instance B uses Y_OFFSET=300 (row clamp) and H_RES=8 (short frame for wrap).
// Inputs shared except valid and reset; a select picks which outputs are tallied.
module tb_trace_plotter;

  localparam logic [2:0] BG = 3'b000;
  localparam logic [2:0] TR = 3'b010;

  logic       i_clk = 1'b0;
  logic       a_rst_n, b_rst_n;
  logic [7:0] i_sample;
  logic       a_valid, b_valid, i_freeze;

  logic        a_ready, a_wr_en, a_fd, b_ready, b_wr_en, b_fd;
  logic [18:0] a_addr, b_addr;
  logic [2:0]  a_data, b_data;
  logic [9:0]  a_col, b_col;

  logic        msel;
  logic        m_ready, m_wr_en, m_fd;
  logic [18:0] m_addr;
  logic [2:0]  m_data;

  int n_tests = 0;
  int n_fail  = 0;
  int busy, n_bg, n_tr, n_oth, n_rdy, n_fd;
  int first_tr, last_tr, first_bg, last_bg;

  always #5 i_clk = ~i_clk;

  trace_plotter u_a (
    .i_clk(i_clk), .i_rst_n(a_rst_n), .i_sample(i_sample), .i_sample_valid(a_valid),
    .o_sample_ready(a_ready), .i_freeze(i_freeze), .o_wr_en(a_wr_en), .o_wr_addr(a_addr),
    .o_wr_data(a_data), .o_cur_col(a_col), .o_frame_done(a_fd)
  );

  trace_plotter #(.Y_OFFSET(300), .H_RES(8)) u_b (
    .i_clk(i_clk), .i_rst_n(b_rst_n), .i_sample(i_sample), .i_sample_valid(b_valid),
    .o_sample_ready(b_ready), .i_freeze(i_freeze), .o_wr_en(b_wr_en), .o_wr_addr(b_addr),
    .o_wr_data(b_data), .o_cur_col(b_col), .o_frame_done(b_fd)
  );

  assign m_ready = msel ? b_ready : a_ready;
  assign m_wr_en = msel ? b_wr_en : a_wr_en;
  assign m_fd    = msel ? b_fd    : a_fd;
  assign m_addr  = msel ? b_addr  : a_addr;
  assign m_data  = msel ? b_data  : a_data;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample (starting at a negedge), then tally every write until o_wr_en drops.
  task automatic run_sample(input bit sel, input logic [7:0] s, input int freeze_at);
    bit done;
    msel     = sel;
    i_sample = s;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    chk("ready_before_sample", int'(m_ready), 1);
    @(posedge i_clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    busy = 0; n_bg = 0; n_tr = 0; n_oth = 0; n_rdy = 0; n_fd = 0;
    first_tr = -1; last_tr = -1; first_bg = -1; last_bg = -1;
    done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge i_clk);
      if (k == freeze_at) i_freeze = 1'b1;
      if (m_fd) n_fd++;
      if (!m_wr_en) begin
        done = 1'b1;
        break;
      end
      busy++;
      if (m_ready) n_rdy++;
      if (m_data == TR) begin
        if (n_tr == 0) first_tr = int'(m_addr);
        last_tr = int'(m_addr);
        n_tr++;
      end else if (m_data == BG) begin
        if (n_bg == 0) first_bg = int'(m_addr);
        last_bg = int'(m_addr);
        n_bg++;
      end else begin
        n_oth++;
      end
    end
    chk("column_completes_in_budget", int'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nr, nw;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; i_freeze = 1'b0; i_sample = 8'd0; msel = 1'b0;

    // Reset state
    @(negedge i_clk);
    chk("rst_wr_en", int'(a_wr_en), 0);
    chk("rst_wr_addr", int'(a_addr), 0);
    chk("rst_wr_data", int'(a_data), 0);
    chk("rst_frame_done", int'(a_fd), 0);
    chk("rst_ready_low", int'(a_ready), 0);
    chk("rst_cur_col", int'(a_col), 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);

    // Sample 255 at col 0: 480 clears, single pixel at y=112
    run_sample(1'b0, 8'd255, -1);
    chk("t1_busy", busy, 481);
    chk("t1_n_bg", n_bg, 480);
    chk("t1_first_bg", first_bg, 0);
    chk("t1_last_bg", last_bg, 479);
    chk("t1_n_tr", n_tr, 1);
    chk("t1_tr_addr", first_tr, 112);
    chk("t1_other", n_oth, 0);
    chk("t1_ready_low_busy", n_rdy, 0);
    chk("t1_cur_col", int'(a_col), 1);
    chk("t1_addr_holds", int'(a_addr), 112);
    chk("t1_data_holds", int'(a_data), int'(TR));

    // Sample 0 at col 1: segment 112..367
    run_sample(1'b0, 8'd0, -1);
    chk("t2_busy", busy, 736);
    chk("t2_n_tr", n_tr, 256);
    chk("t2_first_tr", first_tr, 1 * 512 + 112);
    chk("t2_last_tr", last_tr, 1 * 512 + 367);
    chk("t2_first_bg", first_bg, 512);
    chk("t2_ready_low_busy", n_rdy, 0);
    chk("t2_cur_col", int'(a_col), 2);

    // Valid low while ready: nothing happens
    nw = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (a_wr_en) nw++;
    end
    chk("idle_no_writes", nw, 0);
    chk("idle_col_holds", int'(a_col), 2);

    // Upward segment 367 -> 167 at col 2, then flat at col 3, then 167 -> 267 at col 4
    run_sample(1'b0, 8'd200, -1);
    chk("t2b_n_tr", n_tr, 201);
    chk("t2b_first_tr", first_tr, 2 * 512 + 167);
    chk("t2b_last_tr", last_tr, 2 * 512 + 367);
    chk("t2b_busy", busy, 681);
    run_sample(1'b0, 8'd200, -1);
    chk("t2c_n_tr", n_tr, 1);
    chk("t2c_tr_addr", first_tr, 3 * 512 + 167);
    run_sample(1'b0, 8'd100, -1);
    chk("t2d_n_tr", n_tr, 101);
    chk("t2d_cur_col", int'(a_col), 5);

    // Freeze during CLEAR of col 5: column completes, ready stays low
    run_sample(1'b0, 8'd100, 100);
    chk("t5_busy", busy, 481);
    chk("t5_tr_addr", first_tr, 5 * 512 + 267);
    chk("t5_cur_col", int'(a_col), 6);
    nr = 0; nw = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (a_ready) nr++;
      if (a_wr_en) nw++;
    end
    chk("t5_ready_held_low", nr, 0);
    chk("t5_no_writes_frozen", nw, 0);
    i_freeze = 1'b0;
    #1;
    chk("t5_ready_after_release", int'(a_ready), 1);
    run_sample(1'b0, 8'd0, -1);
    chk("t5_col6_first_tr", first_tr, 6 * 512 + 267);
    chk("t5_col6_n_tr", n_tr, 101);
    chk("t5_cur_col_after", int'(a_col), 7);

    // Async reset in the middle of DRAW at col 7
    msel = 1'b0;
    i_sample = 8'd255;
    a_valid = 1'b1;
    @(posedge i_clk);
    #1;
    a_valid = 1'b0;
    repeat (490) @(negedge i_clk);
    chk("t6_in_draw_wr_en", int'(a_wr_en), 1);
    chk("t6_in_draw_data", int'(a_data), int'(TR));
    chk("t6_in_draw_addr", int'(a_addr), 7 * 512 + 121);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("t6_wr_en_async", int'(a_wr_en), 0);
    chk("t6_cur_col_async", int'(a_col), 0);
    @(negedge i_clk);
    a_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("t6_cur_col_after", int'(a_col), 0);
    run_sample(1'b0, 8'd0, -1);
    chk("t6_single_pixel", n_tr, 1);
    chk("t6_tr_addr", first_tr, 367);
    chk("t6_cur_col_next", int'(a_col), 1);

    // Instance B: clamp to row 479
    run_sample(1'b1, 8'd0, -1);
    chk("t3_n_tr", n_tr, 1);
    chk("t3_tr_addr_clamped", first_tr, 479);
    chk("t3_last_bg", last_bg, 479);
    run_sample(1'b1, 8'd128, -1);
    chk("t3_seg_n_tr", n_tr, 53);
    chk("t3_seg_first", first_tr, 1 * 512 + 427);
    chk("t3_seg_last", last_tr, 1 * 512 + 479);
    run_sample(1'b1, 8'd255, -1);
    chk("t3_seg2_n_tr", n_tr, 128);

    // Instance B: run to the end of the 8-column frame
    nr = 0;
    for (int c = 3; c < 7; c++) begin
      run_sample(1'b1, 8'd255, -1);
      nr += n_fd;
    end
    chk("t4_no_early_frame_done", nr, 0);
    run_sample(1'b1, 8'd255, -1);
    chk("t4_frame_done_once", n_fd, 1);
    chk("t4_last_col_addr", first_tr, 7 * 512 + 300);
    chk("t4_col_wrapped", int'(b_col), 0);
    @(negedge i_clk);
    chk("t4_frame_done_pulse_ends", int'(b_fd), 0);
    run_sample(1'b1, 8'd0, -1);
    chk("t4_wrap_single_pixel", n_tr, 1);
    chk("t4_wrap_tr_addr", first_tr, 479);
    chk("t4_wrap_frame_done_quiet", n_fd, 0);
    chk("t4_cur_col_after_wrap", int'(b_col), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
